// File: rtl/dehaze_stream_tx.sv
// Frame-timed pixel transmitter: converts a ready/valid pixel source into a free-running
// vsync/href/clken/pixel stream with zero-fill on source underflow.
module dehaze_stream_tx #(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 160,
    parameter int V_ACTIVE = 480,
    parameter int V_BLANK  = 45
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        s_valid,
    input  logic        s_sof,
    input  logic [23:0] s_data,
    output logic        s_ready,
    output logic        post_frame_vsync,
    output logic        post_frame_href,
    output logic        post_frame_clken,
    output logic [23:0] post_img,
    output logic        frame_done,
    output logic [15:0] underflow_cnt,
    output logic        sof_err,
    input  logic        clr_stat
);

    localparam int DATA_W  = 24;
    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = V_ACTIVE + V_BLANK;
    localparam int HCNT_W  = $clog2(H_TOTAL);
    localparam int VCNT_W  = $clog2(V_TOTAL);

    localparam logic [HCNT_W-1:0] H_ACT_C  = HCNT_W'(H_ACTIVE);
    localparam logic [HCNT_W-1:0] H_LAST_C = HCNT_W'(H_TOTAL - 1);
    localparam logic [HCNT_W-1:0] H_ONE    = HCNT_W'(1);
    localparam logic [VCNT_W-1:0] V_ACT_C  = VCNT_W'(V_ACTIVE);
    localparam logic [VCNT_W-1:0] V_LAST_C = VCNT_W'(V_TOTAL - 1);
    localparam logic [VCNT_W-1:0] V_ONE    = VCNT_W'(1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FRAME = 1'b1
    } state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t              r_state;
    state_t              w_state_nx;
    logic [HCNT_W-1:0]   r_hcnt_p0;
    logic [HCNT_W-1:0]   w_hcnt_nx;
    logic [VCNT_W-1:0]   r_vcnt_p0;
    logic [VCNT_W-1:0]   w_vcnt_nx;

    logic                r_vsync_p1;
    logic                r_vld_p1;
    logic [DATA_W-1:0]   r_img_p1;
    logic                r_done_p1;
    logic [15:0]         r_underflow_cnt;
    logic                r_sof_err;

    logic                w_in_frame;
    logic                w_h_last;
    logic                w_v_last;
    logic                w_frame_end;
    logic                w_vact;
    logic                w_active;
    logic                w_xfer;
    logic                w_under;
    logic                w_first;
    logic                w_sof_bad;

    assign w_in_frame  = (r_state == S_FRAME);
    assign w_h_last    = (r_hcnt_p0 == H_LAST_C);
    assign w_v_last    = (r_vcnt_p0 == V_LAST_C);
    assign w_frame_end = w_in_frame & w_h_last & w_v_last;
    assign w_vact      = w_in_frame & (r_vcnt_p0 < V_ACT_C);
    assign w_active    = w_vact & (r_hcnt_p0 < H_ACT_C);
    assign w_xfer      = w_active & s_valid;
    assign w_under     = w_active & ~s_valid;
    assign w_first     = (r_hcnt_p0 == '0) && (r_vcnt_p0 == '0);
    // The first pixel of a frame must carry s_sof, and no other pixel may.
    assign w_sof_bad   = w_xfer & (w_first ? ~s_sof : s_sof);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_hcnt_p0 <= '0;
            r_vcnt_p0 <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_hcnt_p0 <= w_hcnt_nx;
            r_vcnt_p0 <= w_vcnt_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_hcnt_nx  = r_hcnt_p0;
        w_vcnt_nx  = r_vcnt_p0;
        case (r_state)
            S_IDLE: begin
                w_hcnt_nx = '0;
                w_vcnt_nx = '0;
                if (run) w_state_nx = S_FRAME;
            end
            S_FRAME: begin
                // run is only consulted at frame end, so frames are never truncated.
                if (w_h_last) begin
                    w_hcnt_nx = '0;
                    if (w_v_last) begin
                        w_vcnt_nx  = '0;
                        w_state_nx = run ? S_FRAME : S_IDLE;
                    end else begin
                        w_vcnt_nx = r_vcnt_p0 + V_ONE;
                    end
                end else begin
                    w_hcnt_nx = r_hcnt_p0 + H_ONE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Stage p1: stream outputs registered one cycle after the counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync_p1 <= 1'b0;
            r_vld_p1   <= 1'b0;
            r_img_p1   <= '0;
            r_done_p1  <= 1'b0;
        end else begin
            r_vsync_p1 <= w_vact;
            r_vld_p1   <= w_active;
            r_img_p1   <= w_xfer ? s_data : '0;
            r_done_p1  <= w_frame_end;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_underflow_cnt <= '0;
            r_sof_err       <= 1'b0;
        end else if (clr_stat) begin
            r_underflow_cnt <= '0;
            r_sof_err       <= 1'b0;
        end else begin
            if (w_under)   r_underflow_cnt <= sat_inc(r_underflow_cnt);
            if (w_sof_bad) r_sof_err       <= 1'b1;
        end
    end

    assign s_ready          = w_active;
    assign post_frame_vsync = r_vsync_p1;
    assign post_frame_href  = r_vld_p1;
    assign post_frame_clken = r_vld_p1;
    assign post_img         = r_img_p1;
    assign frame_done       = r_done_p1;
    assign underflow_cnt    = r_underflow_cnt;
    assign sof_err          = r_sof_err;

endmodule

// File: tb/tb_dehaze_stream_tx.sv
// Bench for dehaze_stream_tx: directed frames on a 4/2/3/2 geometry with a pixel scoreboard,
// plus a 64/1/64/1 instance driven starved to reach underflow saturation.
module tb_dehaze_stream_tx;

    localparam int H_A = 4;
    localparam int H_B = 2;
    localparam int V_A = 3;
    localparam int V_B = 2;
    localparam int H_T = H_A + H_B;
    localparam int V_T = V_A + V_B;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        s_valid;
    logic        s_sof;
    logic [23:0] s_data;
    logic        clr_stat;
    logic        s_ready;
    logic        vs;
    logic        href;
    logic        clken;
    logic [23:0] img;
    logic        fd;
    logic [15:0] ucnt;
    logic        serr;

    logic        sat_run;
    logic        sat_valid;
    logic        sat_sof;
    logic [23:0] sat_data;
    logic        sat_clr;
    logic        sat_ready;
    logic        sat_vs;
    logic        sat_href;
    logic        sat_clken;
    logic [23:0] sat_img;
    logic        sat_fd;
    logic [15:0] sat_ucnt;
    logic        sat_serr;

    int          n_chk;
    int          n_err;
    logic [23:0] exp_q[$];
    logic [23:0] mon_e;
    bit          fresh;
    bit          p_act;
    bit          p_vs;
    bit          p_last;
    int          since_done;
    int          vs_cnt;
    int          ck_cnt;
    int          hp_cnt;
    logic        prev_href;

    dehaze_stream_tx #(.H_ACTIVE(H_A), .H_BLANK(H_B), .V_ACTIVE(V_A), .V_BLANK(V_B)) u_dut (
        .clk(clk), .rst_n(rst_n), .run(run), .s_valid(s_valid), .s_sof(s_sof), .s_data(s_data),
        .s_ready(s_ready), .post_frame_vsync(vs), .post_frame_href(href), .post_frame_clken(clken),
        .post_img(img), .frame_done(fd), .underflow_cnt(ucnt), .sof_err(serr), .clr_stat(clr_stat)
    );

    dehaze_stream_tx #(.H_ACTIVE(64), .H_BLANK(1), .V_ACTIVE(64), .V_BLANK(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .run(sat_run), .s_valid(sat_valid), .s_sof(sat_sof),
        .s_data(sat_data), .s_ready(sat_ready), .post_frame_vsync(sat_vs),
        .post_frame_href(sat_href), .post_frame_clken(sat_clken), .post_img(sat_img),
        .frame_done(sat_fd), .underflow_cnt(sat_ucnt), .sof_err(sat_serr), .clr_stat(sat_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_vsync"}, 32'(vs), 32'd0);
        chk({tag, "_href"}, 32'(href), 32'd0);
        chk({tag, "_clken"}, 32'(clken), 32'd0);
        chk({tag, "_img"}, 32'(img), 32'd0);
        chk({tag, "_frame_done"}, 32'(fd), 32'd0);
        chk({tag, "_underflow_cnt"}, 32'(ucnt), 32'd0);
        chk({tag, "_sof_err"}, 32'(serr), 32'd0);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    endtask

    task automatic check_idle(input int n, input bit first_fd);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_vsync", 32'(vs), 32'd0);
            chk("idle_clken", 32'(clken), 32'd0);
            chk("idle_href", 32'(href), 32'd0);
            chk("idle_img", 32'(img), 32'd0);
            chk("idle_s_ready", 32'(s_ready), 32'd0);
            chk("idle_frame_done", 32'(fd), 32'(first_fd && i == 0));
            @(posedge clk); #1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after run is sampled in IDLE.
    task automatic start_run();
        fresh  = 1'b1;
        p_act  = 1'b0;
        p_vs   = 1'b0;
        p_last = 1'b0;
        run    = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic drive_frame(input logic [23:0] base, input int wa, input int wb,
                               input bit bad_sof, input int clr_pos, input int drop_pos,
                               input int stop_pos);
        for (int v = 0; v < V_T; v++) begin
            for (int h = 0; h < H_T; h++) begin
                int pos;
                int idx;
                bit act;
                pos = v * H_T + h;
                if (stop_pos >= 0 && pos >= stop_pos) return;
                idx = v * H_A + h;
                act = (h < H_A) && (v < V_A);
                clr_stat = (pos == clr_pos);
                if (pos == drop_pos) run = 1'b0;
                if (act) begin
                    s_sof = bad_sof ? (idx == 3) : (idx == 0);
                    if (idx == wa || idx == wb) begin
                        s_valid = 1'b0;
                        s_data  = 24'hDEAD00;
                        exp_q.push_back(24'h0);
                    end else begin
                        s_valid = 1'b1;
                        s_data  = base + 24'(idx);
                        exp_q.push_back(base + 24'(idx));
                    end
                end else begin
                    // Valid garbage outside the active region must never be taken.
                    s_valid = 1'b1;
                    s_sof   = 1'b0;
                    s_data  = 24'hBADBAD;
                end
                @(negedge clk);
                chk("s_ready", 32'(s_ready), 32'(act));
                chk("clken", 32'(clken), 32'(p_act));
                chk("href", 32'(href), 32'(p_act));
                chk("vsync", 32'(vs), 32'(p_vs));
                chk("frame_done", 32'(fd), 32'(p_last));
                if (bad_sof && pos == 1) chk("sof_err_first", 32'(serr), 32'd1);
                if (clr_pos >= 0 && pos == clr_pos + 1) begin
                    chk("clr_underflow_cnt", 32'(ucnt), 32'd0);
                    chk("clr_sof_err", 32'(serr), 32'd0);
                end
                @(posedge clk); #1;
                p_act  = act;
                p_vs   = (v < V_A);
                p_last = (pos == V_T * H_T - 1);
            end
        end
        clr_stat = 1'b0;
        s_valid  = 1'b0;
        s_sof    = 1'b0;
    endtask

    // Scoreboard monitor: pops one expected pixel per clken and tallies per-frame shape.
    initial begin
        since_done = 0; vs_cnt = 0; ck_cnt = 0; hp_cnt = 0; prev_href = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                since_done = 0; vs_cnt = 0; ck_cnt = 0; hp_cnt = 0; prev_href = 1'b0;
            end else begin
                since_done++;
                if (clken) begin
                    if (exp_q.size() == 0) begin
                        chk("sb_nonempty", 32'(exp_q.size()), 32'd1);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("post_img", 32'(img), 32'(mon_e));
                    end
                    ck_cnt++;
                end
                if (vs) vs_cnt++;
                if (href && !prev_href) hp_cnt++;
                prev_href = href;
                if (fd) begin
                    chk("frame_vsync_cycles", 32'(vs_cnt), 32'd18);
                    chk("frame_clken_cycles", 32'(ck_cnt), 32'd12);
                    chk("frame_href_pulses", 32'(hp_cnt), 32'd3);
                    if (!fresh) chk("frame_period", 32'(since_done), 32'd30);
                    fresh = 1'b0;
                    since_done = 0; vs_cnt = 0; ck_cnt = 0; hp_cnt = 0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_err = 0;
        rst_n = 1'b0; run = 1'b0; s_valid = 1'b0; s_sof = 1'b0; s_data = '0; clr_stat = 1'b0;
        sat_run = 1'b0; sat_valid = 1'b0; sat_sof = 1'b0; sat_data = '0; sat_clr = 1'b0;
        fresh = 1'b1; p_act = 1'b0; p_vs = 1'b0; p_last = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        check_idle(3, 1'b0);

        // Two clean frames, run held high, data 0..11.
        start_run();
        drive_frame(24'h000000, -1, -1, 1'b0, -1, -1, -1);
        drive_frame(24'h000000, -1, -1, 1'b0, -1, -1, -1);
        chk("clean_underflow_cnt", 32'(ucnt), 32'd0);
        chk("clean_sof_err", 32'(serr), 32'd0);

        // Source starves pixels 5 and 6.
        drive_frame(24'h100000, 5, 6, 1'b0, -1, -1, -1);
        chk("starve_underflow_cnt", 32'(ucnt), 32'd2);
        chk("starve_sof_err", 32'(serr), 32'd0);

        // s_sof missing on pixel 0, present on pixel 3.
        drive_frame(24'hABCD00, -1, -1, 1'b1, -1, -1, -1);
        chk("badsof_sof_err", 32'(serr), 32'd1);
        chk("badsof_underflow_cnt", 32'(ucnt), 32'd2);

        // clr_stat on the first pixel, run dropped during line 1: frame still completes.
        drive_frame(24'h200000, -1, -1, 1'b0, 0, 7, -1);
        check_idle(8, 1'b1);

        // Asynchronous reset during line 1.
        start_run();
        drive_frame(24'h300000, 5, -1, 1'b1, -1, -1, 9);
        chk("prerst_underflow_cnt", 32'(ucnt), 32'd1);
        chk("prerst_sof_err", 32'(serr), 32'd1);
        chk("prerst_clken", 32'(clken), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        exp_q.delete();
        s_valid = 1'b0;
        s_sof   = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        start_run();
        drive_frame(24'h400000, -1, -1, 1'b0, -1, -1, -1);
        chk("post_rst_underflow_cnt", 32'(ucnt), 32'd0);
        chk("post_rst_sof_err", 32'(serr), 32'd0);
        drive_frame(24'h500000, -1, -1, 1'b0, -1, 0, -1);
        check_idle(4, 1'b1);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        // Starved 64/1/64/1 instance: 4096 underflows per 4225-cycle frame.
        sat_run = 1'b1;
        @(posedge clk); #1;
        repeat (4225) @(posedge clk);
        #1;
        chk("sat_one_frame", 32'(sat_ucnt), 32'd4096);
        repeat (64000) @(posedge clk);
        #1;
        chk("sat_saturated", 32'(sat_ucnt), 32'hFFFF);
        chk("sat_sof_err", 32'(sat_serr), 32'd0);
        sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        chk("sat_clr_priority", 32'(sat_ucnt), 32'd0);
        @(posedge clk); #1;
        chk("sat_after_clr", 32'(sat_ucnt), 32'd1);
        sat_run = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/dehaze_stream_tx.md
# dehaze_stream_tx

Video stream transmitter for the dehaze pipeline. It turns a ready/valid pixel source (frame buffer reader or testbench feeder) into the frame-timed vsync/href/clken/24-bit pixel stream that the source-path delay alignment and the dark-channel stages consume. Frame geometry is fixed by parameters. Timing is free-running while enabled and never stalls on the source. Source underflow is filled with zero pixels and counted.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_BLANK, 160, blanking cycles per line (≥1)
- V_ACTIVE, 480, active lines per frame
- V_BLANK, 45, blank lines per frame (≥1)
- clk  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- run  in  1  level enable; frames start while high
- s_valid  in  1  source pixel valid
- s_sof  in  1  source flag: this pixel is first of a frame
- s_data  in  24  source pixel {R,G,B}
- s_ready  out  1  transmitter takes pixel this cycle
- post_frame_vsync  out  1  frame valid
- post_frame_href  out  1  line valid
- post_frame_clken  out  1  pixel strobe
- post_img  out  24  pixel
- frame_done  out  1  one-cycle pulse at end of each frame
- underflow_cnt  out  16  saturating count of zero-filled pixels
- sof_err  out  1  sticky: first pixel of frame lacked s_sof, or s_sof on a non-first pixel
- clr_stat  in  1  synchronous clear of underflow_cnt and sof_err

## Operation
- States: IDLE, FRAME.
- IDLE: hcnt = vcnt = 0. s_ready = 0. Timing outputs are 0. run = 1 → FRAME.
- FRAME: hcnt counts 0..H_ACTIVE+H_BLANK−1 and wraps. vcnt increments on each hcnt wrap and counts 0..V_ACTIVE+V_BLANK−1.
- Active region: hcnt < H_ACTIVE and vcnt < V_ACTIVE. In FRAME, s_ready = active region, decoded combinationally from registered counters.
- Frame end (last hcnt of last vcnt):
  - frame_done pulses with the next output cycle.
  - If run = 1, counters wrap to 0 and stay in FRAME with no gap cycle.
  - If run = 0, go to IDLE.
- Deasserting run mid-frame never truncates the frame. Re-asserting it before frame end continues seamlessly.
- Pixel transfer happens when s_valid & s_ready. If s_valid = 0 in the active region, the output pixel is 24'h0, clken still fires, and underflow_cnt increments, saturating at 16'hFFFF.
- sof_err is set when either holds:
  - a transfer at hcnt = 0, vcnt = 0 has s_sof = 0;
  - any other transfer has s_sof = 1.
- The offending pixel is still transmitted. No resync is attempted.
- Widths: hcnt is $clog2(H_ACTIVE+H_BLANK) bits; vcnt is $clog2(V_ACTIVE+V_BLANK) bits.
- clr_stat takes priority over an increment or set in the same cycle.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- All stream outputs are registered, one cycle after the counter state:
  - post_frame_vsync = (vcnt < V_ACTIVE) in FRAME
  - post_frame_href = post_frame_clken = active region
  - post_img = accepted s_data, or 0 on underflow or outside the active region
- Start latency: run sampled high in IDLE at cycle N. At N+1: FRAME, counters 0, s_ready = 1. At N+2: vsync = href = clken = 1 with the pixel accepted at N+1.
- vsync stays high through the horizontal blanking of active lines. It falls on the first output cycle of line V_ACTIVE.
- href is high for exactly H_ACTIVE consecutive cycles per active line, followed by H_BLANK low cycles.
- Frame period is (H_ACTIVE+H_BLANK)·(V_ACTIVE+V_BLANK) cycles.
- frame_done coincides with the output cycle of the last blank position.
- Asynchronous reset mid-frame clears everything immediately, including the statistics. After release, the block restarts from IDLE.

## Test plan
- Geometry 4/2/3/2, run held high, source always valid with incrementing data and correct s_sof → per frame: 3 href pulses of 4 cycles, gaps of 2, vsync high for 18 cycles then low for 12, frame period 30, post_img sequence 0..11 each frame, underflow_cnt = 0, sof_err = 0.
- Start latency: run rises at cycle N from IDLE → first clken at N+2. Drop run mid-frame → frame completes, frame_done pulses, outputs stay 0 afterwards.
- Source withholds s_valid for pixels 5 and 6 → those two pixels are emitted as 0 with clken = 1, underflow_cnt = 2, and later pixels are shifted by no cycles.
- s_sof missing on the first pixel, then asserted on pixel 3 → sof_err = 1 after the first transfer and stays set. clr_stat pulse → 0.
- Force underflow_cnt near saturation (long starved run) → holds at 16'hFFFF. clr_stat in the same cycle as an underflow → 0.
- Assert rst_n low during line 1 → all outputs 0 asynchronously. After release with run = 1, a fresh frame starts with 2-cycle latency.
